multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences a multicycle MIPS datapath: shared instruction/data memory, IR, A/B, ALUOut and Data registers, with one ALU reused across cycles.
- Decodes op/funct once per instruction and steps fetch/decode/execute/memory/writeback.
- Inserts memory wait states using a ready handshake.
- Flags unsupported encodings.

Parameters:
- ALU_ADD, 3'b010, alucontrol encoding for add
- ALU_SUB, 3'b110, alucontrol encoding for subtract
- None other; opcode and funct values below are fixed.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- op  input  6  instr[31:26] from IR
- funct  input  6  instr[5:0] from IR
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes current access this cycle
- pcen  output  1  PC register enable
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  output  1  memory write strobe
- irwrite  output  1  IR load enable
- regdst  output  1  write register select: 1 = rd, 0 = rt
- memtoreg  output  1  writeback select: 1 = Data register, 0 = ALUOut
- regwrite  output  1  register file write enable
- alusrca  output  1  ALU A select: 0 = PC, 1 = A register
- alusrcb  output  2  ALU B select: 00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
- pcsrc  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  output  3  ALU operation
- retire  output  1  one-cycle pulse on the final cycle of each instruction
- illegal  output  1  sticky unsupported-instruction flag
- state  output  4  current state, for debug

Behaviour:
- Async reset (reset_n = 0): state = FETCH (0), illegal = 0. All outputs take FETCH-state values. Deasserting reset does not start an access before the next clk edge.
- Defaults for every output not listed per state: 0, except alucontrol = ALU_ADD.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11. Codes 12-15 are unreachable and go to FETCH.
- FETCH:
  - iord = 0, alusrca = 0, alusrcb = 01, pcsrc = 00.
  - irwrite = pcen = mem_ready.
  - Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE:
  - alusrca = 0, alusrcb = 11 (branch target into ALUOut).
  - Next state by op:
    - 100011 (lw) and 101011 (sw) -> MEMADR
    - 000000 (R-type) -> RTEX
    - 000100 (beq) -> BEQEX
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JEX
  - Any other op -> FETCH with illegal set and retire = 1.
  - R-type with funct outside {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt} -> FETCH, same handling.
- MEMADR: alusrca = 1, alusrcb = 10. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: iord = 1. Holds until mem_ready = 1, then goes to MEMWB.
- MEMWB: regdst = 0, memtoreg = 1, regwrite = 1, retire = 1. Next state FETCH.
- MEMWR:
  - iord = 1, memwrite = 1 on every cycle in this state.
  - Holds until mem_ready = 1, then goes to FETCH with retire = 1 on that cycle.
- RTEX:
  - alusrca = 1, alusrcb = 00.
  - alucontrol from funct: add 010, sub 110, and 000, or 001, slt 111.
  - Next state RTWB.
- RTWB: regdst = 1, memtoreg = 0, regwrite = 1, retire = 1. Next state FETCH.
- BEQEX:
  - alusrca = 1, alusrcb = 00, alucontrol = ALU_SUB, pcsrc = 01.
  - pcen = zero (combinational).
  - retire = 1. Next state FETCH.
- ADDIEX: alusrca = 1, alusrcb = 10. Next state ADDIWB.
- ADDIWB: regdst = 0, memtoreg = 0, regwrite = 1, retire = 1. Next state FETCH.
- JEX: pcsrc = 10, pcen = 1, retire = 1. Next state FETCH.
- Cycle counts with mem_ready tied to 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2. Each cycle with mem_ready = 0 in FETCH, MEMRD or MEMWR adds 1.
- Signal timing:
  - pcen, irwrite and retire are combinational from state, mem_ready and zero.
  - All other outputs depend on state only, except alucontrol in RTEX, which also depends on funct.
- illegal is set on the clk edge that leaves DECODE for an unsupported encoding. Only reset clears it.
- Reset asserted in any state, including a wait in MEMWR, immediately forces memwrite = 0 and state = FETCH.

Test Plan:
- Reset, then lw (op 100011) with mem_ready = 1:
  - state sequence 0,1,2,3,4,0.
  - regwrite = 1 and memtoreg = 1 only in state 4.
  - retire pulses once.
- sw with mem_ready = 0 for 3 cycles in MEMWR:
  - memwrite = 1 for exactly 4 cycles, iord = 1 throughout.
  - then FETCH; total 7 cycles.
- R-type sub (funct 100010) then slt (funct 101010):
  - alucontrol = 110, then 111 in RTEX.
  - regdst = 1 in RTWB.
- beq twice, with zero = 1 then zero = 0 in BEQEX: pcen = 1 on the first and 0 on the second; pcsrc = 01 both times.
- FETCH with mem_ready held low 5 cycles: pcen = irwrite = 0 throughout; both pulse 1 on the ready cycle; state then 1.
- Illegal cases and reset:
  - op 111111 -> DECODE back to FETCH; illegal = 1 and stays 1 across a following addi.
  - R-type funct 000000 also sets illegal.
  - reset_n low mid-MEMWR -> memwrite = 0 and illegal = 0 immediately.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS datapath: sequences fetch/decode/execute/mem/writeback.
// Memory stalls in FETCH/MEMRD/MEMWR via mem_ready; unsupported encodings set a sticky illegal flag.
module multicycle_ctrl #(
  parameter logic [2:0] ALU_ADD = 3'b010,
  parameter logic [2:0] ALU_SUB = 3'b110
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_RTEX   = 4'd6;
  localparam logic [3:0] S_RTWB   = 4'd7;
  localparam logic [3:0] S_BEQEX  = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JEX    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       funct_ok;
  logic       op_ok;
  logic       dec_illegal;

  always_comb begin
    funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
    op_ok    = (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_J) || ((op == OP_RTYPE) && funct_ok);
    dec_illegal = !op_ok;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (dec_illegal) begin
          state_d   = S_FETCH;
          illegal_d = 1'b1;
        end else begin
          case (op)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_RTEX;
            OP_BEQ:       state_d = S_BEQEX;
            OP_ADDI:      state_d = S_ADDIEX;
            OP_J:         state_d = S_JEX;
            default:      state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_RTEX:   state_d = S_RTWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_RTWB, S_BEQEX, S_ADDIWB, S_JEX: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pcen       = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcen    = mem_ready;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        retire  = dec_illegal;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        retire   = mem_ready;
      end
      S_RTEX: begin
        alusrca = 1'b1;
        case (funct)
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = 3'b000;
          FN_OR:   alucontrol = 3'b001;
          FN_SLT:  alucontrol = 3'b111;
          default: alucontrol = ALU_ADD;
        endcase
      end
      S_RTWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = zero;
        retire     = 1'b1;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_JEX: begin
        pcsrc  = 2'b10;
        pcen   = 1'b1;
        retire = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: stimulus pushes expected output vectors, a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       retire, illegal;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  logic [20:0] exp_q[$];
  string       lbl_q[$];

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .retire(retire), .illegal(illegal), .state(state)
  );

  // Expected outputs per state, written out from the state table.
  // Packing: {state, pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc, alucontrol, retire, illegal}
  function automatic logic [20:0] expv(input logic [3:0] st, input logic mr, input logic z,
                                       input logic [5:0] fn, input logic dil, input logic ill);
    logic pe, io, mw, iw, rd, mt, rw, sa, rt;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    pe = 0; io = 0; mw = 0; iw = 0; rd = 0; mt = 0; rw = 0; sa = 0; rt = 0;
    sb = 2'b00; ps = 2'b00; ac = 3'b010;
    case (st)
      4'd0:  begin sb = 2'b01; pe = mr; iw = mr; end
      4'd1:  begin sb = 2'b11; rt = dil; end
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  io = 1;
      4'd4:  begin mt = 1; rw = 1; rt = 1; end
      4'd5:  begin io = 1; mw = 1; rt = mr; end
      4'd6:  begin
        sa = 1;
        case (fn)
          6'b100010: ac = 3'b110;
          6'b100100: ac = 3'b000;
          6'b100101: ac = 3'b001;
          6'b101010: ac = 3'b111;
          default:   ac = 3'b010;
        endcase
      end
      4'd7:  begin rd = 1; rw = 1; rt = 1; end
      4'd8:  begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; rt = 1; end
      4'd9:  begin sa = 1; sb = 2'b10; end
      4'd10: begin rw = 1; rt = 1; end
      4'd11: begin ps = 2'b10; pe = 1; rt = 1; end
      default: ;
    endcase
    return {st, pe, io, mw, iw, rd, mt, rw, sa, sb, ps, ac, rt, ill};
  endfunction

  // One cycle: drive inputs just after the edge and queue what the DUT must show this cycle.
  task automatic step(input logic r, input logic [3:0] st, input logic [5:0] o, input logic [5:0] f,
                      input logic mr, input logic z, input logic dil, input logic ill, input string lb);
    @(posedge clk);
    #1;
    reset_n   = r;
    op        = o;
    funct     = f;
    mem_ready = mr;
    zero      = z;
    exp_q.push_back(expv(st, mr, z, f, dil, ill));
    lbl_q.push_back(lb);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [20:0] e, a;
      string lb;
      e  = exp_q.pop_front();
      lb = lbl_q.pop_front();
      a  = {state, pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
            alusrcb, pcsrc, alucontrol, retire, illegal};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got %b expected %b (t=%0t)", lb, a, e, $time);
      end
    end
  end

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, JJ = 6'b000010, BAD = 6'b111111;
  localparam logic [5:0] F_SUB = 6'b100010, F_SLT = 6'b101010, F_BAD = 6'b000000;

  initial begin
    reset_n = 0; op = 0; funct = 0; zero = 0; mem_ready = 0;
    // reset holds FETCH regardless of mem_ready
    step(0, 0, LW, 0, 1, 0, 0, 0, "reset0");
    step(0, 0, LW, 0, 0, 0, 0, 0, "reset1");
    // lw, mem_ready high: 0,1,2,3,4
    step(1, 0, LW, 0, 1, 0, 0, 0, "lw_fetch");
    step(1, 1, LW, 0, 1, 0, 0, 0, "lw_decode");
    step(1, 2, LW, 0, 1, 0, 0, 0, "lw_memadr");
    step(1, 3, LW, 0, 1, 0, 0, 0, "lw_memrd");
    step(1, 4, LW, 0, 1, 0, 0, 0, "lw_memwb");
    // sw with three wait cycles in MEMWR: 7 cycles total
    step(1, 0, SW, 0, 1, 0, 0, 0, "sw_fetch");
    step(1, 1, SW, 0, 1, 0, 0, 0, "sw_decode");
    step(1, 2, SW, 0, 1, 0, 0, 0, "sw_memadr");
    step(1, 5, SW, 0, 0, 0, 0, 0, "sw_wait1");
    step(1, 5, SW, 0, 0, 0, 0, 0, "sw_wait2");
    step(1, 5, SW, 0, 0, 0, 0, 0, "sw_wait3");
    step(1, 5, SW, 0, 1, 0, 0, 0, "sw_done");
    // R-type sub then slt
    step(1, 0, RT, F_SUB, 1, 0, 0, 0, "sub_fetch");
    step(1, 1, RT, F_SUB, 1, 0, 0, 0, "sub_decode");
    step(1, 6, RT, F_SUB, 1, 0, 0, 0, "sub_rtex");
    step(1, 7, RT, F_SUB, 1, 0, 0, 0, "sub_rtwb");
    step(1, 0, RT, F_SLT, 1, 0, 0, 0, "slt_fetch");
    step(1, 1, RT, F_SLT, 1, 0, 0, 0, "slt_decode");
    step(1, 6, RT, F_SLT, 1, 0, 0, 0, "slt_rtex");
    step(1, 7, RT, F_SLT, 1, 0, 0, 0, "slt_rtwb");
    // beq taken then not taken
    step(1, 0, BEQ, 0, 1, 0, 0, 0, "beq1_fetch");
    step(1, 1, BEQ, 0, 1, 0, 0, 0, "beq1_decode");
    step(1, 8, BEQ, 0, 1, 1, 0, 0, "beq1_ex_z1");
    step(1, 0, BEQ, 0, 1, 0, 0, 0, "beq2_fetch");
    step(1, 1, BEQ, 0, 1, 0, 0, 0, "beq2_decode");
    step(1, 8, BEQ, 0, 1, 0, 0, 0, "beq2_ex_z0");
    // fetch stalled five cycles, then a jump
    for (int i = 0; i < 5; i++) step(1, 0, JJ, 0, 0, 0, 0, 0, "fetch_stall");
    step(1, 0, JJ, 0, 1, 0, 0, 0, "fetch_ready");
    step(1, 1, JJ, 0, 1, 0, 0, 0, "j_decode");
    step(1, 11, JJ, 0, 1, 0, 0, 0, "j_jex");
    // illegal opcode, then addi with sticky flag
    step(1, 0, BAD, 0, 1, 0, 0, 0, "bad_fetch");
    step(1, 1, BAD, 0, 1, 0, 1, 0, "bad_decode");
    step(1, 0, ADDI, 0, 1, 0, 0, 1, "addi_fetch");
    step(1, 1, ADDI, 0, 1, 0, 0, 1, "addi_decode");
    step(1, 9, ADDI, 0, 1, 0, 0, 1, "addi_ex");
    step(1, 10, ADDI, 0, 1, 0, 0, 1, "addi_wb");
    // reset during a MEMWR wait clears memwrite and illegal at once
    step(1, 0, SW, 0, 1, 0, 0, 1, "swr_fetch");
    step(1, 1, SW, 0, 1, 0, 0, 1, "swr_decode");
    step(1, 2, SW, 0, 1, 0, 0, 1, "swr_memadr");
    step(1, 5, SW, 0, 0, 0, 0, 1, "swr_wait");
    step(0, 0, SW, 0, 0, 0, 0, 0, "swr_reset");
    // R-type with unsupported funct
    step(1, 0, RT, F_BAD, 1, 0, 0, 0, "badfn_fetch");
    step(1, 1, RT, F_BAD, 1, 0, 1, 0, "badfn_decode");
    step(1, 0, RT, F_BAD, 0, 0, 0, 1, "badfn_after");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
